// File: rtl/uart_ctrl_pkg.sv
// ============================================================================
// Module   : uart_ctrl_pkg
// Brief    : Shared types and UART register map for the UART sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package uart_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_POLL_AR = 3'd1,
        ST_POLL_R  = 3'd2,
        ST_TX_AW_W = 3'd3,
        ST_TX_B    = 3'd4,
        ST_RX_AR   = 3'd5,
        ST_RX_R    = 3'd6
    } state_e;

    localparam logic       UART_ADDR_DATA   = 1'b0;
    localparam logic       UART_ADDR_STATUS = 1'b1;
    localparam int         STATUS_TX_FREE   = 0;
    localparam int         STATUS_RX_PEND   = 1;
    localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_ctrl_if.sv
// ============================================================================
// Module   : uart_ctrl_if
// Brief    : AXI-Lite bus between the UART sequencer and the UART peripheral.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface uart_ctrl_if;
    logic        awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

`default_nettype wire

// File: rtl/axil_single_master.sv
// ============================================================================
// Module   : axil_single_master
// Brief    : One-beat AXI-Lite read/write engine; the caller holds each *_go_i
//            for as long as it sits in the matching phase.
// Revision : 1.0
// ============================================================================
`default_nettype none

module axil_single_master
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_BITS = 8
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 ar_go_i,
    input  wire logic                 ar_addr_i,
    input  wire logic                 r_go_i,
    input  wire logic                 wr_go_i,
    input  wire logic [DATA_BITS-1:0] wdata_i,
    input  wire logic                 b_go_i,
    output logic                      ar_done_o,
    output logic                      r_done_o,
    output logic                      wr_done_o,
    output logic                      b_done_o,
    output logic [DATA_BITS-1:0]      rdata_o,
    output logic [1:0]                status_o,
    output logic [1:0]                rresp_o,
    output logic [1:0]                bresp_o,
    uart_ctrl_if.master               m
);

    logic aw_done_q;
    logic w_done_q;
    logic w_aw_hs;
    logic w_w_hs;

    assign m.arvalid = ar_go_i;
    assign m.araddr  = ar_addr_i;
    assign m.arprot  = 3'b000;
    assign m.rready  = r_go_i;
    assign ar_done_o = ar_go_i && m.arready;
    assign r_done_o  = r_go_i && m.rvalid;
    assign rdata_o   = m.rdata[DATA_BITS-1:0];
    assign status_o  = m.rdata[1:0];
    assign rresp_o   = m.rresp;

    // AW and W retire independently; each valid drops after its own handshake.
    assign m.awvalid = wr_go_i && !aw_done_q;
    assign m.wvalid  = wr_go_i && !w_done_q;
    assign m.awaddr  = UART_ADDR_DATA;
    assign m.awprot  = 3'b000;
    assign m.wdata   = 32'(wdata_i);
    assign m.wstrb   = 4'b0001;
    assign w_aw_hs   = m.awvalid && m.awready;
    assign w_w_hs    = m.wvalid && m.wready;
    assign wr_done_o = (aw_done_q || w_aw_hs) && (w_done_q || w_w_hs);

    assign m.bready  = b_go_i;
    assign b_done_o  = b_go_i && m.bvalid;
    assign bresp_o   = m.bresp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (wr_done_o) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (w_aw_hs) aw_done_q <= 1'b1;
            if (w_w_hs)  w_done_q  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_ctrl.sv
// ============================================================================
// Module   : uart_ctrl
// Brief    : Polls a UART over AXI-Lite, forwarding bytes from two packet-locked
//            round-robin requesters and buffering one received byte.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int DATA_BITS     = 8,
    parameter int POLL_INTERVAL = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [DATA_BITS-1:0] req0_data,
    input  wire logic                 req0_last,
    input  wire logic                 req0_valid,
    output logic                      req0_ready,
    input  wire logic [DATA_BITS-1:0] req1_data,
    input  wire logic                 req1_last,
    input  wire logic                 req1_valid,
    output logic                      req1_ready,
    output logic [DATA_BITS-1:0]      rx_data,
    output logic                      rx_valid,
    input  wire logic                 rx_ready,
    input  wire logic                 rx_en,
    uart_ctrl_if.master               m,
    output logic [1:0]                grant,
    output logic                      err
);

    localparam int                CNT_W   = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(POLL_INTERVAL - 1);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   sel_q, sel_d;
    logic                   last_q, last_d;
    logic [DATA_BITS-1:0]   tx_data_q, tx_data_d;
    logic                   lock_q, lock_d;
    logic                   lock_id_q, lock_id_d;
    logic                   rr_q, rr_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   err_q;

    logic                   w_ar_done, w_r_done, w_wr_done, w_b_done;
    logic [DATA_BITS-1:0]   w_rdata;
    logic [1:0]             w_status, w_rresp, w_bresp;
    logic [1:0]             w_req_valid;
    logic                   w_pick_vld, w_pick_id;

    axil_single_master #(.DATA_BITS(DATA_BITS)) u_axil (
        .clk       (clk),
        .rst       (rst),
        .ar_go_i   ((state_q == ST_POLL_AR) || (state_q == ST_RX_AR)),
        .ar_addr_i ((state_q == ST_POLL_AR) ? UART_ADDR_STATUS : UART_ADDR_DATA),
        .r_go_i    ((state_q == ST_POLL_R) || (state_q == ST_RX_R)),
        .wr_go_i   (state_q == ST_TX_AW_W),
        .wdata_i   (tx_data_q),
        .b_go_i    (state_q == ST_TX_B),
        .ar_done_o (w_ar_done),
        .r_done_o  (w_r_done),
        .wr_done_o (w_wr_done),
        .b_done_o  (w_b_done),
        .rdata_o   (w_rdata),
        .status_o  (w_status),
        .rresp_o   (w_rresp),
        .bresp_o   (w_bresp),
        .m         (m)
    );

    assign w_req_valid = {req1_valid, req0_valid};

    // A held lock makes only its owner eligible; otherwise rr_q gets first pick.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick_id  = rr_q;
        if (lock_q) begin
            w_pick_id  = lock_id_q;
            w_pick_vld = w_req_valid[lock_id_q];
        end else if (w_req_valid[rr_q]) begin
            w_pick_vld = 1'b1;
        end else if (w_req_valid[~rr_q]) begin
            w_pick_id  = ~rr_q;
            w_pick_vld = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        last_d     = last_q;
        tx_data_d  = tx_data_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        rr_d       = rr_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    state_d = ST_POLL_AR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_POLL_AR: if (w_ar_done) state_d = ST_POLL_R;
            ST_POLL_R: begin
                if (w_r_done) begin
                    if (w_status[STATUS_RX_PEND] && rx_en && !rx_valid_q) begin
                        state_d = ST_RX_AR;
                    end else if (w_status[STATUS_TX_FREE] && w_pick_vld) begin
                        state_d    = ST_TX_AW_W;
                        sel_d      = w_pick_id;
                        tx_data_d  = w_pick_id ? req1_data : req0_data;
                        last_d     = w_pick_id ? req1_last : req0_last;
                        req0_ready = !w_pick_id;
                        req1_ready = w_pick_id;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            ST_TX_AW_W: if (w_wr_done) state_d = ST_TX_B;
            ST_TX_B: begin
                if (w_b_done) begin
                    if (last_q) begin
                        lock_d = 1'b0;
                        rr_d   = ~sel_q;
                    end else begin
                        lock_d    = 1'b1;
                        lock_id_d = sel_q;
                    end
                    state_d = ST_POLL_AR;
                end
            end
            ST_RX_AR: if (w_ar_done) state_d = ST_RX_R;
            ST_RX_R: begin
                if (w_r_done) begin
                    rx_data_d  = w_rdata;
                    rx_valid_d = 1'b1;
                    state_d    = ST_POLL_AR;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_WAIT;
            cnt_q      <= '0;
            sel_q      <= 1'b0;
            last_q     <= 1'b0;
            tx_data_q  <= '0;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            rr_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            tx_data_q  <= tx_data_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            rr_q       <= rr_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            err_q      <= (w_r_done && (w_rresp != AXI_RESP_OKAY)) ||
                          (w_b_done && (w_bresp != AXI_RESP_OKAY));
        end
    end

    always_comb begin
        grant = 2'b00;
        if (lock_q) begin
            grant = onehot2(lock_id_q);
        end else if ((state_q == ST_TX_AW_W) || (state_q == ST_TX_B)) begin
            grant = onehot2(sel_q);
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign err      = err_q;

endmodule

`default_nettype wire
